// File: rtl/neuron_mac_seq_if.sv
// Handshake bundle for neuron_mac_seq: input pair stream and result stream.
// in_data/w_data/in_valid/in_ready/idx carry sign-magnitude pairs into the engine,
// res/out_valid/out_ready carry the activated result out. master = producer/consumer side, slave = engine.
interface neuron_mac_seq_if #(
  parameter int DW    = 8,
  parameter int OUT_W = 16,
  parameter int IDX_W = 4
);
  logic [DW-1:0]    in_data;
  logic [DW-1:0]    w_data;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] idx;
  logic [OUT_W-1:0] res;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, w_data, in_valid, out_ready,
    input  in_ready, idx, res, out_valid
  );

  modport slave (
    input  in_data, w_data, in_valid, out_ready,
    output in_ready, idx, res, out_valid
  );
endinterface

// File: rtl/neuron_mac_seq.sv
// Single-neuron engine: bias-preloaded saturating signed MAC over N_INPUTS sign-magnitude pairs, then activation.
// Latency: start -> in_ready next cycle; last pair accepted at k -> out_valid at k+2 (min N_INPUTS+2 from start).
// Backpressure: pairs wait while in_valid=0; result held in DONE with out_valid=1 until out_ready=1.
//
// Ports:
//   clk, reg_rst      clock and synchronous active-high reset
//   start/mode/bias   begin evaluation; activation select and bias are latched on start in IDLE
//   pif (slave)       in_data/w_data/in_valid/in_ready/idx pair stream, res/out_valid/out_ready result stream
//   busy              high whenever the engine is not IDLE
module neuron_mac_seq #(
  parameter int DW       = 8,
  parameter int N_INPUTS = 16,
  parameter int ACC_W    = 20,
  parameter int OUT_W    = 16,
  parameter int IDX_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic             clk,
  input  logic             reg_rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [OUT_W-1:0] bias,
  neuron_mac_seq_if.slave  pif,
  output logic             busy
);

  // Width of the unsigned product of two magnitudes.
  localparam int PW = 2 * (DW - 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  // Accumulator clamp limits.
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Output range limits, both at result width and sign-extended to accumulator width
  // so the activation compares stay in one signed domain.
  localparam logic [OUT_W-1:0]        OUT_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]        OUT_MIN   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OUT_MAX_A = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN_A = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ACT   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic signed [ACC_W-1:0] acc_q;
  logic [IDX_W-1:0]        idx_q;
  logic [1:0]              mode_q;
  logic [OUT_W-1:0]        res_q;

  logic                    load;
  logic                    accept;
  logic                    last_pair;

  logic [DW-2:0]           in_mag;
  logic [DW-2:0]           w_mag;
  logic [PW-1:0]           prod_mag;
  logic                    prod_neg;
  logic signed [ACC_W:0]   term;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W-1:0] acc_sat;
  logic signed [ACC_W-1:0] bias_ext;
  logic [OUT_W-1:0]        act_res;

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  assign load      = (state_q == IDLE) && start;
  assign accept    = (state_q == ACCUM) && pif.in_valid;
  assign last_pair = (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reg_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (pif.in_valid && last_pair) state_d = ACT;
      ACT:     state_d = DONE;
      DONE:    if (pif.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode registered state only, so no input reaches them combinationally.
  always_comb begin
    pif.in_ready  = 1'b0;
    pif.out_valid = 1'b0;
    busy          = 1'b1;
    unique case (state_q)
      IDLE:    busy = 1'b0;
      ACCUM:   pif.in_ready = 1'b1;
      ACT:     ;
      DONE:    pif.out_valid = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign pif.idx = idx_q;
  assign pif.res = res_q;

  // ---------------------------------------------------------------------------
  // Multiply-accumulate
  // ---------------------------------------------------------------------------
  assign in_mag   = pif.in_data[DW-2:0];
  assign w_mag    = pif.w_data[DW-2:0];
  assign prod_mag = PW'(in_mag) * PW'(w_mag);
  // A zero product is +0 whatever the operand signs, so -0 never perturbs the sum.
  assign prod_neg = (pif.in_data[DW-1] ^ pif.w_data[DW-1]) && (prod_mag != '0);

  assign bias_ext = ACC_W'($signed(bias));

  // One extra bit of headroom makes overflow visible as a disagreement of the top two bits;
  // the clamped value is what gets stored, so later terms continue from the rail.
  always_comb begin
    term = $signed({{(ACC_W+1-PW){1'b0}}, prod_mag});
    if (prod_neg) begin
      term = -term;
    end
    sum = {acc_q[ACC_W-1], acc_q} + term;
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      acc_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_sat = sum[ACC_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Activation (mode 3 behaves as identity)
  // ---------------------------------------------------------------------------
  always_comb begin
    act_res = '0;
    unique case (mode_q)
      2'd0: begin
        if (acc_q[ACC_W-1]) begin
          act_res = '0;
        end else if (acc_q > OUT_MAX_A) begin
          act_res = OUT_MAX;
        end else begin
          act_res = acc_q[OUT_W-1:0];
        end
      end
      2'd2: begin
        act_res = (!acc_q[ACC_W-1] && (acc_q != '0)) ? OUT_W'(1) : '0;
      end
      default: begin
        if (acc_q > OUT_MAX_A) begin
          act_res = OUT_MAX;
        end else if (acc_q < OUT_MIN_A) begin
          act_res = OUT_MIN;
        end else begin
          act_res = acc_q[OUT_W-1:0];
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // res is only written in ACT, so it keeps the previous result through IDLE.
  always_ff @(posedge clk) begin
    if (reg_rst) begin
      acc_q  <= '0;
      idx_q  <= '0;
      mode_q <= 2'd0;
      res_q  <= '0;
    end else begin
      if (load) begin
        acc_q  <= bias_ext;
        idx_q  <= '0;
        mode_q <= mode;
      end else if (accept) begin
        acc_q <= acc_sat;
        idx_q <= last_pair ? '0 : idx_q + IDX_W'(1);
      end
      if (state_q == ACT) begin
        res_q <= act_res;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  idx_in_range: assert property (@(posedge clk) disable iff (reg_rst) idx_q <= LAST_IDX);

  res_held_in_done: assert property (@(posedge clk) disable iff (reg_rst)
    (state_q == DONE) && !pif.out_ready |=> $stable(res_q) && (state_q == DONE));

endmodule

// File: tb/tb_neuron_mac_seq.sv
module tb_neuron_mac_seq;

  logic        clk;
  logic        reg_rst;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] bias;
  logic [7:0]  in_data;
  logic [7:0]  w_data;
  logic        in_valid;
  logic        out_ready;
  logic        busy0;
  logic        busy1;

  int checks = 0;
  int errors = 0;

  logic [7:0] pin [16];
  logic [7:0] pw  [16];

  // d0: default parameters; d1: narrow accumulator that saturates readily.
  neuron_mac_seq_if #(.DW(8), .OUT_W(16), .IDX_W(4)) i0 ();
  neuron_mac_seq_if #(.DW(8), .OUT_W(16), .IDX_W(4)) i1 ();

  assign i0.in_data   = in_data;
  assign i0.w_data    = w_data;
  assign i0.in_valid  = in_valid;
  assign i0.out_ready = out_ready;
  assign i1.in_data   = in_data;
  assign i1.w_data    = w_data;
  assign i1.in_valid  = in_valid;
  assign i1.out_ready = out_ready;

  neuron_mac_seq d0 (
    .clk(clk), .reg_rst(reg_rst), .start(start), .mode(mode), .bias(bias),
    .pif(i0), .busy(busy0)
  );

  neuron_mac_seq #(.ACC_W(16)) d1 (
    .clk(clk), .reg_rst(reg_rst), .start(start), .mode(mode), .bias(bias),
    .pif(i1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic over the stored pairs with clamping after every term.
  function automatic longint model(input int accw, input logic [1:0] md, input logic [15:0] b);
    longint acc, hi, lo, p;
    hi  = (longint'(1) <<< (accw - 1)) - 1;
    lo  = -(longint'(1) <<< (accw - 1));
    acc = longint'($signed(b));
    for (int i = 0; i < 16; i++) begin
      p = longint'(pin[i][6:0]) * longint'(pw[i][6:0]);
      if (pin[i][7] != pw[i][7]) p = -p;
      acc = acc + p;
      if (acc > hi) acc = hi;
      if (acc < lo) acc = lo;
    end
    case (md)
      2'd0:    return (acc < 0) ? 0 : ((acc > 32767) ? 32767 : acc);
      2'd2:    return (acc > 0) ? 1 : 0;
      default: return (acc > 32767) ? 32767 : ((acc < -32768) ? -32768 : acc);
    endcase
  endfunction

  // One full evaluation of the pairs in pin/pw. stall: 0 none, 1 idle cycle before every pair,
  // 2 random idle cycles. hold: cycles with out_ready low (start pulsed) once the result is up.
  task automatic eval(input logic [1:0] md, input logic [15:0] b, input int stall, input int hold,
                      input longint e0, input longint e1, input string nm);
    start = 1'b1;
    mode  = md;
    bias  = b;
    tick();
    start = 1'b0;
    mode  = 2'($urandom);
    bias  = 16'($urandom);
    chk({nm, " in_ready@1"}, longint'(i0.in_ready), 1);
    chk({nm, " busy@1"}, longint'(busy0), 1);
    for (int i = 0; i < 16; i++) begin
      if (stall == 1 || (stall == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        w_data   = 8'($urandom);
        tick();
        chk({nm, " idx stall"}, longint'(i0.idx), i);
      end
      in_valid = 1'b1;
      in_data  = pin[i];
      w_data   = pw[i];
      chk({nm, " idx"}, longint'(i0.idx), i);
      chk({nm, " in_ready"}, longint'(i1.in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
    chk({nm, " act out_valid"}, longint'(i0.out_valid), 0);
    chk({nm, " act in_ready"}, longint'(i0.in_ready), 0);
    chk({nm, " act idx"}, longint'(i0.idx), 0);
    tick();
    chk({nm, " out_valid d0"}, longint'(i0.out_valid), 1);
    chk({nm, " out_valid d1"}, longint'(i1.out_valid), 1);
    chk({nm, " res d0"}, longint'($signed(i0.res)), e0);
    chk({nm, " res d1"}, longint'($signed(i1.res)), e1);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      tick();
      chk({nm, " hold out_valid"}, longint'(i0.out_valid), 1);
      chk({nm, " hold res"}, longint'($signed(i0.res)), e0);
      chk({nm, " hold busy"}, longint'(busy1), 1);
    end
    // start in the handshake cycle must not launch a new evaluation.
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk({nm, " post out_valid"}, longint'(i0.out_valid), 0);
    chk({nm, " post busy d0"}, longint'(busy0), 0);
    chk({nm, " post busy d1"}, longint'(busy1), 0);
    chk({nm, " post in_ready"}, longint'(i0.in_ready), 0);
    chk({nm, " post res held"}, longint'($signed(i1.res)), e1);
  endtask

  typedef struct {
    logic [1:0]  md;
    logic [15:0] b;
    int          sp;
    logic [7:0]  a0, b0, a1, b1;
    int          stall;
    int          hold;
    longint      e0, e1;
  } vec_t;

  vec_t tbl [14];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Pairs below index sp use (a0,b0), the rest use (a1,b1).
    tbl[0]  = '{2'd1, 16'd0,     1,  8'h85, 8'h03, 8'h80, 8'h7F, 0, 0,  -15,    -15};
    tbl[1]  = '{2'd0, 16'd100,   16, 8'h0A, 8'h8A, 8'h0A, 8'h8A, 1, 0,  0,      0};
    tbl[2]  = '{2'd1, 16'd0,     16, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 0, 0,  32767,  32767};
    tbl[3]  = '{2'd1, 16'd0,     16, 8'hFF, 8'h7F, 8'hFF, 8'h7F, 0, 0,  -32768, -32768};
    tbl[4]  = '{2'd2, 16'd0,     1,  8'h01, 8'h01, 8'h00, 8'h00, 0, 10, 1,      1};
    tbl[5]  = '{2'd2, 16'hFFFB,  1,  8'h01, 8'h01, 8'h00, 8'h00, 0, 0,  0,      0};
    tbl[6]  = '{2'd0, 16'd0,     16, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 2, 2,  32767,  32767};
    tbl[7]  = '{2'd1, 16'd0,     3,  8'h7F, 8'h7F, 8'hFF, 8'h01, 0, 0,  32767,  31116};
    tbl[8]  = '{2'd1, 16'd0,     8,  8'h7F, 8'h7F, 8'hFF, 8'h7F, 0, 1,  0,      -32768};
    tbl[9]  = '{2'd3, 16'd1234,  16, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0,  1234,   1234};
    tbl[10] = '{2'd1, 16'hFED4,  1,  8'h82, 8'h83, 8'h00, 8'h00, 0, 0,  -294,   -294};
    tbl[11] = '{2'd1, 16'd7,     16, 8'h80, 8'h80, 8'h80, 8'h80, 1, 0,  7,      7};
    tbl[12] = '{2'd0, 16'd0,     1,  8'h05, 8'h85, 8'h03, 8'h04, 0, 0,  155,    155};
    tbl[13] = '{2'd2, 16'd0,     16, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0,  0,      0};

    reg_rst   = 1'b1;
    start     = 1'b0;
    mode      = 2'd0;
    bias      = 16'd0;
    in_data   = 8'd0;
    w_data    = 8'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reg_rst = 1'b0;

    // Idle with pairs offered: nothing must be taken.
    in_valid = 1'b1;
    in_data  = 8'h7F;
    w_data   = 8'h7F;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle in_ready", longint'(i0.in_ready), 0);
      chk("idle out_valid", longint'(i0.out_valid), 0);
      chk("idle busy", longint'(busy0), 0);
      chk("idle idx", longint'(i0.idx), 0);
      chk("idle res", longint'(i0.res), 0);
    end
    in_valid = 1'b0;

    for (int k = 0; k < 14; k++) begin
      for (int i = 0; i < 16; i++) begin
        pin[i] = (i < tbl[k].sp) ? tbl[k].a0 : tbl[k].a1;
        pw[i]  = (i < tbl[k].sp) ? tbl[k].b0 : tbl[k].b1;
      end
      eval(tbl[k].md, tbl[k].b, tbl[k].stall, tbl[k].hold, tbl[k].e0, tbl[k].e1,
           $sformatf("vec%0d", k));
    end

    // Reset in the middle of accumulation discards the partial sum.
    start = 1'b1;
    mode  = 2'd1;
    bias  = 16'd77;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h7F;
      w_data   = 8'h7F;
      tick();
    end
    chk("midrst idx before", longint'(i0.idx), 7);
    in_valid = 1'b0;
    reg_rst  = 1'b1;
    tick();
    reg_rst = 1'b0;
    chk("midrst busy d0", longint'(busy0), 0);
    chk("midrst busy d1", longint'(busy1), 0);
    chk("midrst idx", longint'(i0.idx), 0);
    chk("midrst in_ready", longint'(i0.in_ready), 0);
    for (int i = 0; i < 16; i++) begin
      pin[i] = 8'h00;
      pw[i]  = 8'h00;
    end
    eval(2'd1, 16'd5, 0, 0, 5, 5, "midrst fresh");

    // Randomized evaluations against the reference model for both accumulator widths.
    for (int r = 0; r < 40; r++) begin
      logic [1:0]  md;
      logic [15:0] b;
      md = 2'($urandom);
      b  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 400)) - 200);
      for (int i = 0; i < 16; i++) begin
        pin[i] = 8'($urandom);
        pw[i]  = 8'($urandom);
        if ($urandom_range(0, 5) == 0) pin[i][6:0] = 7'd0;
      end
      eval(md, b, 2, $urandom_range(0, 3), model(20, md, b), model(16, md, b),
           $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Sequential, parametrised single-neuron engine: accepts a stream of sign-magnitude input/weight pairs over a valid/ready handshake and multiply-accumulates them with correct signed arithmetic into a saturating two's-complement accumulator preloaded with a bias. After N_INPUTS pairs it applies a selectable activation and presents the result on a valid/ready output port. It is the controller-plus-datapath successor to the fixed 16-input, 8-bit neuron datapath in the network layer, and sits between the weight/input memories and the layer output buffer.

## Interface
- DW, 8, width of each sign-magnitude operand (bit DW-1 = sign, DW-2:0 = magnitude)
- N_INPUTS, 16, pairs per neuron evaluation (≥1)
- ACC_W, 20, accumulator width, two's complement (≥ 2*(DW-1)+1)
- OUT_W, 16, result width, two's complement (≤ ACC_W)
- IDX_W, $clog2(N_INPUTS) (min 1), index width
- clk  in  1  clock, all logic on rising edge
- reg_rst  in  1  synchronous, active-high reset
- start  in  1  begin evaluation (sampled only in IDLE)
- mode  in  2  activation: 0 ReLU, 1 identity, 2 step, 3 reserved (= identity); latched at start
- bias  in  OUT_W  two's-complement bias, sign-extended to ACC_W, latched at start
- in_data  in  DW  sign-magnitude input sample
- w_data  in  DW  sign-magnitude weight
- in_valid  in  1  pair valid
- in_ready  out  1  engine accepts pair this cycle
- idx  out  IDX_W  index of next pair expected (weight/input address)
- res  out  OUT_W  activated result
- out_valid  out  1  res valid
- out_ready  in  1  downstream accepts res
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ACCUM, ACT, DONE. reg_rst forces IDLE from any state, any cycle, including mid-evaluation; partial sums discarded.
- IDLE: start=1 → acc ← sext(bias), idx ← 0, latch mode → ACCUM. start in any other state ignored.
- ACCUM: in_ready=1. On in_valid&in_ready: product magnitude = in_mag*w_mag (2*(DW-1) bits); sign = in_sign^w_sign; zero magnitude product is +0 regardless of sign (negative zero contributes 0). acc ← sat(acc ± product). idx increments. Accepting pair N_INPUTS-1 → ACT. in_valid low: hold, no change.
- Saturation: sum computed at ACC_W+1 bits; clamps to +2^(ACC_W-1)-1 / −2^(ACC_W-1); once saturated, later opposite-sign terms subtract from the clamped value (no sticky flag).
- ACT (1 cycle): res ← f(acc): ReLU: acc<0 → 0, else min(acc, 2^(OUT_W-1)-1); identity: acc clamped to OUT_W signed range; step: 1 if acc>0 else 0. → DONE.
- DONE: out_valid=1, res stable. out_ready=1 → IDLE next cycle (start in that same cycle ignored). Held indefinitely while out_ready=0.
- idx wraps to 0 on entry to ACT; never exceeds N_INPUTS-1.

## Timing
- Reset values: in_ready=0, out_valid=0, busy=0, idx=0, res=0, acc=0.
- in_ready, out_valid, busy are functions of registered state only (no combinational input→output paths).
- start at cycle 0 → in_ready=1 from cycle 1. Full-rate: one pair per cycle, N_INPUTS cycles minimum.
- Last pair accepted at cycle k → ACT at k+1 → out_valid=1 at k+2. Minimum start-to-out_valid = N_INPUTS+2 cycles.
- Handshake at cycle d (out_valid&out_ready) → out_valid=0, busy=0 at d+1; next start accepted at d+1 earliest.
- res holds its last value in IDLE until the next ACT overwrites it.

## Test plan
- Reset/idle: reg_rst 2 cycles, then idle 5 cycles with in_valid=1 → in_ready=0, out_valid=0, busy=0, idx=0, res=0; no accumulation.
- Signed MAC, defaults, mode=1, bias=0: 16 pairs, pair0 in=0x85(−5) w=0x03(+3), rest in=0x80(−0) w=0x7F → res=−15 (0xFFF1) at cycle 18 after start; −0 terms contribute nothing.
- Bias+ReLU+stall: bias=100, mode=0, pairs all in=0x0A w=0x8A (−100 each), in_valid toggled every other cycle → res=0, out_valid exactly 2 cycles after 16th acceptance; idx steps only on accepted pairs.
- Saturation: ACC_W=16, OUT_W=16, mode=1, 16 pairs 0x7F×0x7F (16129) → acc clamps 32767, res=0x7FFF; then 16 pairs 0xFF×0x7F from bias 0 → res=0x8000.
- Step mode and backpressure: mode=2, one pair +1×+1, rest 0 → res=1; hold out_ready=0 for 10 cycles → out_valid and res stable; start pulses during DONE ignored; out_ready=1 → IDLE next cycle.
- Reset mid-operation: assert reg_rst after 7 accepted pairs → next cycle IDLE, idx=0, busy=0; fresh start with all-zero pairs, bias=5, mode=1 → res=5 (no residue).
